// File: rtl/wide_add_pkg.sv
// Shared types and sizing helpers for the wide add/subtract sequencer.
package wide_add_pkg;

    localparam int SLICE_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width; a single-slice build still needs a 1-bit index.
    function automatic int idx_width(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds its payload stable while valid is high and ready is low.
interface wide_add_sequencer_if #(
    parameter int WORDS = 4
);
    localparam int W = 32 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/THIRTY_TWO_BIT_ADDER.sv
// 32-bit ripple-carry adder built from bit-level full adders.
module THIRTY_TWO_BIT_ADDER (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[32];

endmodule

// File: rtl/wide_add_sequencer.sv
// Sequences a WORDS x 32-bit add/subtract through one 32-bit ripple adder,
// least significant slice first, carrying between slices in a register.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wide_add_sequencer_if.slave   bus,
    output state_t                state_dbg
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [W-1:0]       a_q, b_q, sum_q;
    logic               carry_q, cout_q, ovf_q;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_cout;
    logic               last;

    assign slice_a = a_q[SLICE_W * int'(idx_q) +: SLICE_W];
    assign slice_b = b_q[SLICE_W * int'(idx_q) +: SLICE_W];
    assign last    = (idx_q == LAST_IDX);

    THIRTY_TWO_BIT_ADDER u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Subtraction is a + ~b + ~borrow, so B and the carry are inverted on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ^ bus.cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[SLICE_W * int'(idx_q) +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (last) begin
                        cout_q <= slice_cout;
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (slice_sum[SLICE_W-1] != a_q[W-1]);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer at WORDS=4 and WORDS=1.
module tb_wide_add_sequencer;
    import wide_add_pkg::*;

    localparam int W4 = 128;
    localparam int W1 = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wide_add_sequencer_if #(.WORDS(4)) bus4 ();
    wide_add_sequencer_if #(.WORDS(1)) bus1 ();
    state_t st4, st1;

    wide_add_sequencer #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave), .state_dbg(st4));
    wide_add_sequencer #(.WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .state_dbg(st1));

    int n_checks = 0;
    int n_fail   = 0;

    // Expected results as {cout, overflow, sum}.
    logic [W4+1:0] exp_q[$];
    logic [W1+1:0] exp1_q[$];

    task automatic check(input string tag, input logic [W4+1:0] got, input logic [W4+1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    function automatic logic [W4+1:0] model4(input logic [W4-1:0] a, input logic [W4-1:0] b,
                                             input logic cin, input logic sub);
        logic [W4:0]   full;
        logic [W4-1:0] s;
        logic          c, ovf;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b} + (W4+1)'(cin);
            s    = full[W4-1:0];
            c    = full[W4];
            ovf  = (a[W4-1] == b[W4-1]) && (s[W4-1] != a[W4-1]);
        end else begin
            s   = a - b - W4'(cin);
            c   = ({1'b0, a} >= ({1'b0, b} + (W4+1)'(cin)));
            ovf = (a[W4-1] != b[W4-1]) && (s[W4-1] != a[W4-1]);
        end
        return {c, ovf, s};
    endfunction

    function automatic logic [W1+1:0] model1(input logic [W1-1:0] a, input logic [W1-1:0] b,
                                             input logic cin, input logic sub);
        logic [W1:0]   full;
        logic [W1-1:0] s;
        logic          c, ovf;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b} + (W1+1)'(cin);
            s    = full[W1-1:0];
            c    = full[W1];
            ovf  = (a[W1-1] == b[W1-1]) && (s[W1-1] != a[W1-1]);
        end else begin
            s   = a - b - W1'(cin);
            c   = ({1'b0, a} >= ({1'b0, b} + (W1+1)'(cin)));
            ovf = (a[W1-1] != b[W1-1]) && (s[W1-1] != a[W1-1]);
        end
        return {c, ovf, s};
    endfunction

    // Returns just after the accepting edge, i.e. inside cycle 1.
    task automatic send4(input logic [W4-1:0] a, input logic [W4-1:0] b,
                         input logic cin, input logic sub, input bit push);
        int guard = 0;
        @(negedge clk);
        bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub; bus4.in_valid = 1'b1;
        while (bus4.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) timeout("send4_ready");
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        if (push) exp_q.push_back(model4(a, b, cin, sub));
    endtask

    task automatic recv4(input string tag, input int exp_lat);
        int lat = 1;
        logic [W4+1:0] e;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        while (bus4.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) begin
            timeout({tag, "_valid"});
        end else begin
            check({tag, "_latency"}, W4'(lat), W4'(exp_lat));
            if (exp_q.size() == 0) begin
                timeout({tag, "_queue"});
            end else begin
                e = exp_q.pop_front();
                check(tag, {bus4.cout, bus4.overflow, bus4.sum}, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic op1(input string tag, input logic [W1-1:0] a, input logic [W1-1:0] b,
                       input logic cin, input logic sub);
        int lat = 1;
        logic [W1+1:0] e;
        @(negedge clk);
        bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub;
        bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        check({tag, "_in_ready"}, W4'(bus1.in_ready), W4'(1));
        @(posedge clk);
        #1 bus1.in_valid = 1'b0;
        exp1_q.push_back(model1(a, b, cin, sub));
        @(negedge clk);
        while (bus1.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) begin
            timeout({tag, "_valid"});
        end else begin
            check({tag, "_latency"}, W4'(lat), W4'(2));
            e = exp1_q.pop_front();
            check(tag, W4'({bus1.cout, bus1.overflow, bus1.sum}), W4'(e));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W4+1:0] snap, e;
        logic [W4-1:0] ra, rb;
        logic          rc, rs;
        logic          seen;
        int            guard;

        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", W4'(bus4.in_ready), W4'(0));
        check("rst_in_ready_w1", W4'(bus1.in_ready), W4'(0));
        check("rst_out_valid", W4'(bus4.out_valid), W4'(0));
        check("rst_result", {bus4.cout, bus4.overflow, bus4.sum}, '0);
        check("rst_state", W4'(st4), W4'(IDLE));
        rst = 1'b0;
        @(posedge clk);
        #1 check("post_rst_in_ready", W4'(bus4.in_ready), W4'(1));

        // Carry ripples through every slice
        send4({W4{1'b1}}, '0, 1'b1, 1'b0, 1'b1);
        recv4("carry_all", 5);

        // Subtract to all-ones with borrow out
        send4('0, W4'(1), 1'b0, 1'b1, 1'b1);
        recv4("sub_all_ones", 5);

        // Signed overflow at the top slice
        send4({1'b0, {(W4-1){1'b1}}}, W4'(1), 1'b0, 1'b0, 1'b1);
        recv4("signed_ovf", 5);

        // Subtract with borrow-in crossing the sign boundary
        send4({1'b1, {(W4-1){1'b0}}}, W4'(1), 1'b1, 1'b1, 1'b1);
        recv4("sub_ovf_bin", 5);

        for (int i = 0; i < 6; i++) begin
            ra = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom(), $urandom()};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send4(ra, rb, rc, rs, 1'b1);
            recv4("random", 5);
        end

        // Backpressure hold, with the next operation already waiting
        bus4.out_ready = 1'b0;
        send4({4{32'h1234_5678}}, {4{32'h0FED_CBA9}}, 1'b0, 1'b0, 1'b1);
        bus4.a = {4{32'hDEAD_BEEF}}; bus4.b = {4{32'h0000_0011}}; bus4.cin = 1'b1; bus4.sub = 1'b1;
        bus4.in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (bus4.out_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) timeout("bp_valid");
        snap = {bus4.cout, bus4.overflow, bus4.sum};
        e = exp_q.pop_front();
        check("bp_result", snap, e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {bus4.cout, bus4.overflow, bus4.sum}, e);
            check("bp_in_ready", W4'(bus4.in_ready), W4'(0));
        end
        bus4.out_ready = 1'b1;
        @(posedge clk);
        #1 check("b2b_in_ready", W4'(bus4.in_ready), W4'(1));
        @(posedge clk);
        #1 bus4.in_valid = 1'b0;
        exp_q.push_back(model4({4{32'hDEAD_BEEF}}, {4{32'h0000_0011}}, 1'b1, 1'b1));
        check("b2b_accepted", W4'(st4), W4'(RUN));
        recv4("b2b", 5);

        // Reset in the second RUN cycle aborts the operation
        send4({W4{1'b1}}, {W4{1'b1}}, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sum", {bus4.cout, bus4.overflow, bus4.sum}, '0);
        check("midrst_in_ready", W4'(bus4.in_ready), W4'(0));
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus4.out_valid === 1'b1) seen = 1'b1;
        end
        check("midrst_no_valid", W4'(seen), W4'(0));
        send4(W4'(5), W4'(7), 1'b0, 1'b0, 1'b1);
        recv4("after_rst", 5);

        // Single-slice build
        op1("w1_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        op1("w1_sub", 32'h3, 32'h5, 1'b0, 1'b1);
        op1("w1_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle wide adder/subtractor that sits directly in front of, and directly behind, the team's 32-bit ripple adder. It accepts two WORDS×32-bit operands through a valid/ready handshake. It feeds one 32-bit slice per cycle into a single THIRTY_TWO_BIT_ADDER instance, least significant slice first, registers each slice result, and chains the slice carry-out into the next slice's carry-in. It then presents the full-width result on a valid/ready output, so one 32-bit adder covers arbitrary operand widths.

## Interface
- WORDS, default 4: number of 32-bit slices; legal range 1..16; total width W = 32*WORDS.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation; high only in IDLE and low while rst is high.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in when sub=0; borrow-in when sub=1.
- sub  input  1  0 computes a+b+cin; 1 computes a−b−cin.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result modulo 2^W.
- cout  output  1  raw carry out of bit W−1; in subtract mode 1 means no borrow.
- overflow  output  1  two's-complement signed overflow of the full-width operation.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid is high, the next edge:
  - captures a;
  - captures b_eff = sub ? ~b : b;
  - loads the carry register with sub ? ~cin : cin;
  - clears the slice index to 0;
  - moves the FSM to RUN.
- RUN: each cycle the adder sees a[idx], b_eff[idx] and the carry register. On the edge:
  - the slice sum is written to sum[idx];
  - the adder carry-out goes to the carry register;
  - idx increments.
- RUN exit: after the slice with idx=WORDS−1, the FSM moves to DONE. At that edge, cout takes that slice's carry-out, and overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- DONE: out_valid=1. sum, cout and overflow hold stable until out_valid && out_ready. After the handshake the FSM returns to IDLE.
- Register reuse: operand registers are loaded only on input acceptance. The sum register is overwritten one slice at a time in RUN.
- Ignored inputs: in_valid outside IDLE and out_ready outside DONE have no effect.
- Slice order: strictly idx 0 to WORDS−1. There is no early termination on carry.
- Arithmetic: every slice is exactly 32 bits, and the carry chains through the carry register only. The carry out of the top slice is never discarded into sum.

## Timing
- Reset values: state=IDLE, out_valid=0, sum=0, cout=0, overflow=0, idx=0, carry register=0. in_ready reads 0 during rst and 1 in the first cycle after rst falls.
- Reset mid-operation: rst in RUN or DONE aborts the operation. No out_valid pulse follows, and partial sum slices are cleared.
- Latency: with acceptance on edge E0, the FSM is in RUN for cycles 1..WORDS, and out_valid rises in cycle WORDS+1.
- Throughput: at most one operation per WORDS+2 cycles. in_ready is never high in the same cycle as out_valid.
- Backpressure: the result holds indefinitely while out_ready=0.
- WORDS=1: RUN lasts one cycle, and out_valid is high in cycle 2.
- Critical path: one 32-bit ripple chain plus the carry-register mux.

## Structure
- Shared package wide_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - SLICE_W=32;
  - the function for the index width, clog2(WORDS), minimum 1.
- Sub-module: exactly one THIRTY_TWO_BIT_ADDER instance, which performs all arithmetic. There is no behavioural '+' at slice width.
- Slice selection: slices are picked with indexed part-selects driven by idx.

## Test plan
- Carry across all slices: WORDS=4, sub=0, a=2^128−1, b=0, cin=1.
  - Required: out_valid in cycle 5, sum=0, cout=1, overflow=0.
- Subtract to all-ones: sub=1, a=0, b=1, cin=0.
  - Required: sum=2^128−1, cout=0 (borrow), overflow=0.
- Signed overflow: sub=0, a=0x7FFF…FFFF, b=1, cin=0.
  - Required: sum=0x8000…0000, overflow=1, cout=0.
- Backpressure then back-to-back: out_ready=0 for 10 cycles, then 1, with in_valid held high.
  - Required: sum, cout and overflow stable and in_ready=0 throughout the hold.
  - Required: second operation accepted in the cycle after the output handshake.
- Reset mid-operation: rst pulsed in the 2nd RUN cycle.
  - Required: out_valid never rises, sum=0.
  - Required: the next operation, a=5, b=7, completes with sum=12.
- Minimum size: WORDS=1, a=0xFFFFFFFF, b=1.
  - Required: sum=0, cout=1, out_valid in cycle 2.
